// File: rtl/washer_pkg.sv
// Shared types and constants for the washer plant model and the controller benches that drive it.
// Dispenser state encoding, wash-phase labels and the default plant timing.
package washer_pkg;

  typedef enum logic [1:0] {
    DISP_IDLE   = 2'd0,
    DISP_DOSING = 2'd1,
    DISP_DONE   = 2'd2
  } disp_state_e;

  typedef enum logic [1:0] {
    PHASE_NONE  = 2'd0,
    PHASE_SOAP  = 2'd1,
    PHASE_RINSE = 2'd2,
    PHASE_SPIN  = 2'd3
  } wash_phase_e;

  localparam int DEF_PRESCALE    = 16;
  localparam int DEF_LEVEL_W     = 8;
  localparam int DEF_FULL_LEVEL  = 200;
  localparam int DEF_DOSE_TICKS  = 4;
  localparam int DEF_CYCLE_TICKS = 600;
  localparam int DEF_SPIN_TICKS  = 300;

  // Bits needed to hold 0..max_val; never returns zero so tiny limits still get a real counter.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/washer_plant_sensor_unit_if.sv
// Controller <-> plant bundle: actuator commands one way, sensor/timer responses the other.
// With WASHER_FAULT_EN defined the bundle also carries the sticky plant fault flag.
interface washer_plant_sensor_unit_if #(
  parameter int LEVEL_W = 8
);
  logic               door_lock;
  logic               fill_value_on;
  logic               drain_value_on;
  logic               motor_on;
  logic               soap_wash;
  logic               water_wash;
  logic               filled;
  logic               drained;
  logic               detergent_added;
  logic               cycle_timeout;
  logic               spin_timeout;
  logic [LEVEL_W-1:0] level;
`ifdef WASHER_FAULT_EN
  logic               fault;
`endif

  modport master (
    output door_lock, fill_value_on, drain_value_on, motor_on, soap_wash, water_wash,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout, level
`ifdef WASHER_FAULT_EN
    , input fault
`endif
  );

  modport slave (
    input  door_lock, fill_value_on, drain_value_on, motor_on, soap_wash, water_wash,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout, level
`ifdef WASHER_FAULT_EN
    , output fault
`endif
  );

endinterface

// File: rtl/washer_tick_gen.sv
// Plant time base: divides clk by PRESCALE and emits a one-clk tick on the last count.
module washer_tick_gen
  import washer_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W = cnt_width(PRESCALE - 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/washer_plant_sensor_unit.sv
// Plant-side model of the washer tub: water level, detergent dispenser, wash and spin timers.
// Define WASHER_FAULT_EN to add the sticky fault monitor that also freezes level and timers.
//
// Dispenser FSM
//   state       | meaning
//   DISP_IDLE   | waiting for a filled, quiet, locked soap phase
//   DISP_DOSING | counting ticks of detergent release
//   DISP_DONE   | dose delivered, detergent_added held until the soap phase ends
module washer_plant_sensor_unit
  import washer_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int FULL_LEVEL  = DEF_FULL_LEVEL,
  parameter int DOSE_TICKS  = DEF_DOSE_TICKS,
  parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS
) (
  input logic                       clk,
  input logic                       reset,
  washer_plant_sensor_unit_if.slave bus
);

  localparam int DOSE_W = cnt_width(DOSE_TICKS);
  localparam int CYC_W  = cnt_width(CYCLE_TICKS);
  localparam int SPIN_W = cnt_width(SPIN_TICKS);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [LEVEL_W-1:0] FULL      = LEVEL_W'(FULL_LEVEL);
  localparam logic [DOSE_W-1:0]  DOSE_LAST = DOSE_W'(DOSE_TICKS - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(CYCLE_TICKS - 1);
  localparam logic [SPIN_W-1:0]  SPIN_LAST = SPIN_W'(SPIN_TICKS - 1);

  logic tick, frozen;
  logic door, fill, drain, motor, soap, water;
  logic dose_en, spin_en;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               filled_q, filled_d;
  logic               drained_q, drained_d;
  disp_state_e        state_q, state_d;
  logic [DOSE_W-1:0]  dose_cnt_q, dose_cnt_d;
  logic               detergent_q, detergent_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               cyc_to_q, cyc_to_d;
  logic [SPIN_W-1:0]  spin_cnt_q, spin_cnt_d;
  logic               spin_to_q, spin_to_d;

  washer_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign door  = bus.door_lock;
  assign fill  = bus.fill_value_on;
  assign drain = bus.drain_value_on;
  assign motor = bus.motor_on;
  assign soap  = bus.soap_wash;
  assign water = bus.water_wash;

  assign dose_en = door & soap & ~water & filled_q & ~fill & ~drain & ~motor;
  assign spin_en = drain & door & drained_q & water;

  always_comb begin
    level_d = level_q;
    if (tick && !frozen) begin
      if (fill && !drain && level_q != LEVEL_MAX)  level_d = level_q + 1'b1;
      else if (drain && !fill && level_q != '0)    level_d = level_q - 1'b1;
    end
    // Flags follow the registered level, so they trail a level change by one clk.
    filled_d  = (level_q >= FULL);
    drained_d = (level_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    dose_cnt_d = dose_cnt_q;
    case (state_q)
      DISP_IDLE: begin
        dose_cnt_d = '0;
        if (dose_en) state_d = DISP_DOSING;
      end
      DISP_DOSING: begin
        if (!dose_en) begin
          state_d    = DISP_IDLE;
          dose_cnt_d = '0;
        end else if (tick) begin
          if (dose_cnt_q == DOSE_LAST) begin
            state_d    = DISP_DONE;
            dose_cnt_d = '0;
          end else begin
            dose_cnt_d = dose_cnt_q + 1'b1;
          end
        end
      end
      DISP_DONE: begin
        if (!soap || water || !door) state_d = DISP_IDLE;
      end
      default: state_d = DISP_IDLE;
    endcase
    detergent_d = (state_d == DISP_DONE);
  end

  // Dropping the motor or the lock clears the wash timer; losing 'filled' only pauses it.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    cyc_to_d  = cyc_to_q;
    if (!(motor && door)) begin
      cyc_cnt_d = '0;
      cyc_to_d  = 1'b0;
    end else if (tick && filled_q && !cyc_to_q && !frozen) begin
      cyc_cnt_d = cyc_cnt_q + 1'b1;
      cyc_to_d  = (cyc_cnt_q == CYC_LAST);
    end
  end

  always_comb begin
    spin_cnt_d = spin_cnt_q;
    spin_to_d  = spin_to_q;
    if (!spin_en) begin
      spin_cnt_d = '0;
      spin_to_d  = 1'b0;
    end else if (tick && !spin_to_q && !frozen) begin
      spin_cnt_d = spin_cnt_q + 1'b1;
      spin_to_d  = (spin_cnt_q == SPIN_LAST);
    end
  end

`ifdef WASHER_FAULT_EN
  localparam int               FILL_LIM = 2 * FULL_LEVEL;
  localparam int               FILL_W   = cnt_width(FILL_LIM);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_LIM);

  logic [1:0]        dry_cnt_q, dry_cnt_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              fault_q, fault_d;

  always_comb begin
    dry_cnt_d  = dry_cnt_q;
    fill_cnt_d = fill_cnt_q;
    if (!(motor && !filled_q))                 dry_cnt_d = '0;
    else if (tick && dry_cnt_q != 2'd3)        dry_cnt_d = dry_cnt_q + 1'b1;
    if (!(fill && !filled_q))                  fill_cnt_d = '0;
    else if (tick && fill_cnt_q != FILL_MAX)   fill_cnt_d = fill_cnt_q + 1'b1;
    fault_d = fault_q
            | (fill & drain)
            | ((fill | drain | motor) & ~door)
            | (dry_cnt_q == 2'd3)
            | (fill_cnt_q == FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dry_cnt_q  <= '0;
      fill_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      dry_cnt_q  <= dry_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign frozen    = fault_q;
  assign bus.fault = fault_q;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q     <= '0;
      filled_q    <= 1'b0;
      drained_q   <= 1'b1;
      state_q     <= DISP_IDLE;
      dose_cnt_q  <= '0;
      detergent_q <= 1'b0;
      cyc_cnt_q   <= '0;
      cyc_to_q    <= 1'b0;
      spin_cnt_q  <= '0;
      spin_to_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      filled_q    <= filled_d;
      drained_q   <= drained_d;
      state_q     <= state_d;
      dose_cnt_q  <= dose_cnt_d;
      detergent_q <= detergent_d;
      cyc_cnt_q   <= cyc_cnt_d;
      cyc_to_q    <= cyc_to_d;
      spin_cnt_q  <= spin_cnt_d;
      spin_to_q   <= spin_to_d;
    end
  end

  assign bus.level           = level_q;
  assign bus.filled          = filled_q;
  assign bus.drained         = drained_q;
  assign bus.detergent_added = detergent_q;
  assign bus.cycle_timeout   = cyc_to_q;
  assign bus.spin_timeout    = spin_to_q;

endmodule

// File: tb/tb_washer_plant_sensor_unit.sv
// Directed closed-loop bench for washer_plant_sensor_unit; expected clk-edge numbers and values are
// queued as stimulus is applied and popped when the plant responds. WASHER_FAULT_EN adds a fault check.
module tb_washer_plant_sensor_unit;

  localparam int PRESCALE    = 2;
  localparam int LEVEL_W     = 8;
  localparam int FULL_LEVEL  = 8;
  localparam int DOSE_TICKS  = 3;
  localparam int CYCLE_TICKS = 10;
  localparam int SPIN_TICKS  = 6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  washer_plant_sensor_unit_if #(.LEVEL_W(LEVEL_W)) bus ();

  washer_plant_sensor_unit #(
    .PRESCALE    (PRESCALE),
    .LEVEL_W     (LEVEL_W),
    .FULL_LEVEL  (FULL_LEVEL),
    .DOSE_TICKS  (DOSE_TICKS),
    .CYCLE_TICKS (CYCLE_TICKS),
    .SPIN_TICKS  (SPIN_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Edge number since reset release; the prescaler wraps on every PRESCALE-th edge.
  int edge_n = 0;
  always @(posedge clk) edge_n <= reset ? edge_n + 1 : 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m, e, lv_exp;

  function automatic int ticks_done(input int first_edge, input int n);
    int c = 0;
    for (int k = first_edge; k < first_edge + 10000; k++) begin
      if (k % PRESCALE == 0) c++;
      if (c == n) return k;
    end
    return -2;
  endfunction

  function automatic logic sel(input int k);
    case (k)
      0:       return bus.filled;
      1:       return bus.drained;
      2:       return bus.detergent_added;
      3:       return bus.cycle_timeout;
      4:       return bus.spin_timeout;
`ifdef WASHER_FAULT_EN
      5:       return bus.fault;
`endif
      default: return 1'bx;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int val);
    exp_t x;
    x.tag = tag;
    x.val = val;
    sb.push_back(x);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t x;
    x.tag = "sb_empty";
    x.val = -999;
    if (sb.size() != 0) x = sb.pop_front();
    n_assert++;
    assert (obs === x.val)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.val);
    end
  endtask

  task automatic wait_sig(input int k, input logic v, input int max_clk, output int edge_seen);
    edge_seen = -1;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (sel(k) === v) begin
        edge_seen = edge_n;
        break;
      end
    end
  endtask

  task automatic wait_level(input int lv, input int max_clk, output int edge_seen);
    edge_seen = -1;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (bus.level === LEVEL_W'(lv)) begin
        edge_seen = edge_n;
        break;
      end
    end
  endtask

  task automatic check_all(input string tag, input int lv, input logic f, input logic d,
                           input logic det, input logic cy, input logic sp);
    sb_push({tag, "_level"}, lv);      sb_check(32'(bus.level));
    sb_push({tag, "_filled"}, f);      sb_check(32'(bus.filled));
    sb_push({tag, "_drained"}, d);     sb_check(32'(bus.drained));
    sb_push({tag, "_detergent"}, det); sb_check(32'(bus.detergent_added));
    sb_push({tag, "_cycle_to"}, cy);   sb_check(32'(bus.cycle_timeout));
    sb_push({tag, "_spin_to"}, sp);    sb_check(32'(bus.spin_timeout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.door_lock      = 1'b0;
    bus.fill_value_on  = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.motor_on       = 1'b0;
    bus.soap_wash      = 1'b0;
    bus.water_wash     = 1'b0;

    // Reset held for three edges, then released with no commands.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_all("idle", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill: one level step per tick, flags trail the level by one clk.
    m = edge_n;
    bus.door_lock     = 1'b1;
    bus.fill_value_on = 1'b1;
    for (int lv = 1; lv <= FULL_LEVEL; lv++) begin
      sb_push($sformatf("fill_edge_lv%0d", lv), ticks_done(m + 1, lv));
      wait_level(lv, 8, e);
      sb_check(32'(e));
      if (lv == 1) begin
        sb_push("drained_lag", 1); sb_check(32'(bus.drained));
        @(negedge clk);
        sb_push("drained_clear", 0); sb_check(32'(bus.drained));
      end
    end
    bus.fill_value_on = 1'b0;
    sb_push("filled_lag", 0); sb_check(32'(bus.filled));
    @(negedge clk);
    sb_push("filled_set", 1); sb_check(32'(bus.filled));

    // Detergent dose: entry on the next edge, then DOSE_TICKS ticks.
    m = edge_n;
    bus.soap_wash = 1'b1;
    sb_push("dose_done_edge", ticks_done(m + 2, DOSE_TICKS));
    wait_sig(2, 1'b1, 20, e);
    sb_check(32'(e));
    m = edge_n;
    bus.water_wash = 1'b1;
    sb_push("dose_clear_edge", m + 1);
    wait_sig(2, 1'b0, 5, e);
    sb_check(32'(e));

    // Wash timer.
    bus.soap_wash  = 1'b0;
    bus.water_wash = 1'b0;
    bus.motor_on   = 1'b1;
    m = edge_n;
    sb_push("cycle_to_edge", ticks_done(m + 1, CYCLE_TICKS));
    wait_sig(3, 1'b1, 40, e);
    sb_check(32'(e));
    sb_push("level_during_wash", FULL_LEVEL); sb_check(32'(bus.level));
    m = edge_n;
    bus.motor_on = 1'b0;
    sb_push("cycle_clear_edge", m + 1);
    wait_sig(3, 1'b0, 5, e);
    sb_check(32'(e));

    // Drain to empty, then spin timer.
    m = edge_n;
    bus.drain_value_on = 1'b1;
    bus.water_wash     = 1'b1;
    lv_exp = ticks_done(m + 1, FULL_LEVEL);
    sb_push("empty_edge", lv_exp);
    wait_level(0, 40, e);
    sb_check(32'(e));
    sb_push("drained_edge", lv_exp + 1);
    wait_sig(1, 1'b1, 5, e);
    sb_check(32'(e));
    sb_push("spin_to_edge", ticks_done(lv_exp + 2, SPIN_TICKS));
    wait_sig(4, 1'b1, 30, e);
    sb_check(32'(e));

    // Dropping the drain clears spin; refill a little, then both valves hold the level.
    m = edge_n;
    bus.drain_value_on = 1'b0;
    bus.fill_value_on  = 1'b1;
    sb_push("spin_clear_edge", m + 1);
    wait_sig(4, 1'b0, 5, e);
    sb_check(32'(e));
    sb_push("refill3_edge", ticks_done(m + 1, 3));
    wait_level(3, 20, e);
    sb_check(32'(e));
    bus.drain_value_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      sb_push($sformatf("both_valves_hold_%0d", i), 3);
      sb_check(32'(bus.level));
    end
    sb_push("both_valves_spin", 0); sb_check(32'(bus.spin_timeout));

`ifdef WASHER_FAULT_EN
    sb_push("fault_both_valves", 1); sb_check(32'(bus.fault));
    reset = 1'b0;
    bus.fill_value_on  = 1'b0;
    bus.drain_value_on = 1'b0;
    @(negedge clk);
    sb_push("fault_reset", 0); sb_check(32'(bus.fault));
    reset = 1'b1;
    bus.door_lock     = 1'b0;
    bus.fill_value_on = 1'b1;
    @(negedge clk);
    sb_push("fault_unlocked_fill", 1); sb_check(32'(bus.fault));
    bus.fill_value_on = 1'b0;
    repeat (3) @(negedge clk);
    sb_push("fault_sticky", 1); sb_check(32'(bus.fault));
    reset = 1'b0;
    @(negedge clk);
    sb_push("fault_cleared", 0); sb_check(32'(bus.fault));
    reset = 1'b1;
`endif

    n_assert++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
